skid_upsizer: RTL and testbench

SKID_UPSIZER -- requirements
Module: skid_upsizer

---
 rtl/skid_pkg.sv | 13 +
 rtl/skid_upsizer.sv | 145 ++++++++++++++
 tb/tb_skid_upsizer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/skid_pkg.sv
// Shared defaults and FSM encoding for the skid-buffered width upsizer.
`timescale 1ns/1ps
package skid_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_RATIO = 4;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_t;

endpackage

// File: rtl/skid_upsizer.sv
// Packs RATIO narrow beats into one wide word; a pending-word register absorbs
// one completed word while the output register is stalled.
//
// state   | meaning
// FILL    | accepting beats (o_ready=1)
// PEND    | a completed word waits for the output register (o_ready=0)
`timescale 1ns/1ps
module skid_upsizer
    import skid_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int RATIO = DEF_RATIO
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DW-1:0]       i_data,
    input  logic                i_last,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DW*RATIO-1:0] o_data,
    output logic [RATIO-1:0]    o_keep,
    output logic                o_last
);

    localparam int            CW        = $clog2(RATIO);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ready;
    logic [CW-1:0]         r_cnt;
    logic [DW*RATIO-1:0]   r_acc_data;
    logic [RATIO-1:0]      r_acc_keep;
    logic [DW*RATIO-1:0]   r_pend_data;
    logic [RATIO-1:0]      r_pend_keep;
    logic                  r_pend_last;
    logic [DW*RATIO-1:0]   r_out_data;
    logic [RATIO-1:0]      r_out_keep;
    logic                  r_out_last;
    logic                  r_out_valid;

    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_complete;
    logic                  w_load_direct;
    logic                  w_load_pend;
    logic [DW*RATIO-1:0]   w_word_data;
    logic [RATIO-1:0]      w_word_keep;

    assign w_in_xfer     = i_valid & r_ready;
    assign w_out_xfer    = r_out_valid & i_ready;
    assign w_complete    = w_in_xfer & ((r_cnt == LAST_LANE) | i_last);
    assign w_load_direct = (r_state == ST_FILL) & w_complete & (~r_out_valid | w_out_xfer);
    assign w_load_pend   = (r_state == ST_FILL) & w_complete & ~w_load_direct;

    // Accumulator contents with the incoming beat merged into lane r_cnt.
    always_comb begin
        w_word_data = r_acc_data;
        w_word_keep = r_acc_keep;
        for (int k = 0; k < RATIO; k++) begin
            if (r_cnt == CW'(k)) begin
                w_word_data[k*DW +: DW] = i_data;
                w_word_keep[k]          = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: if (w_load_pend) w_state_nxt = ST_PEND;
            ST_PEND: if (w_out_xfer)  w_state_nxt = ST_FILL;
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // o_ready is registered from the next state, so i_ready never reaches it combinationally.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_FILL;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_FILL);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt      <= '0;
            r_acc_data <= '0;
            r_acc_keep <= '0;
        end else if (w_complete) begin
            r_cnt      <= '0;
            r_acc_data <= '0;
            r_acc_keep <= '0;
        end else if (w_in_xfer) begin
            r_cnt      <= r_cnt + CW'(1);
            r_acc_data <= w_word_data;
            r_acc_keep <= w_word_keep;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pend_data <= '0;
            r_pend_keep <= '0;
            r_pend_last <= 1'b0;
        end else if (w_load_pend) begin
            r_pend_data <= w_word_data;
            r_pend_keep <= w_word_keep;
            r_pend_last <= i_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load_direct) begin
            r_out_data  <= w_word_data;
            r_out_keep  <= w_word_keep;
            r_out_last  <= i_last;
            r_out_valid <= 1'b1;
        end else if ((r_state == ST_PEND) && w_out_xfer) begin
            r_out_data  <= r_pend_data;
            r_out_keep  <= r_pend_keep;
            r_out_last  <= r_pend_last;
            r_out_valid <= 1'b1;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;
    assign o_keep  = r_out_keep;
    assign o_last  = r_out_last;

endmodule

// File: tb/tb_skid_upsizer.sv
// Scoreboard bench for skid_upsizer (DW=8, RATIO=4): directed words plus a
// randomized run against a lane-array packing model.
`timescale 1ns/1ps
module tb_skid_upsizer;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_data;
    logic        i_last;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [3:0]  o_keep;
    logic        o_last;

    int   tests = 0;
    int   fails = 0;
    bit   use_model = 0;
    exp_t exp_q[$];

    logic [7:0]  m_lane[4];
    int          m_cnt = 0;
    bit          prev_stall = 0;
    logic [31:0] p_d;
    logic [3:0]  p_k;
    logic        p_l;

    skid_upsizer #(.DW(8), .RATIO(4)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_last  (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_t e;
        e.d = d; e.k = k; e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l, output int waited);
        bit acc;
        acc     = 0;
        waited  = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: beat %0h not accepted, actual=no_accept required=accept", d);
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    // Monitor and reference model, both evaluated on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_cnt      = 0;
            prev_stall = 0;
            for (int i = 0; i < 4; i++) m_lane[i] = '0;
        end else begin
            if (prev_stall) begin
                tests++;
                if (!(o_valid === 1'b1 && o_data === p_d && o_keep === p_k && o_last === p_l)) begin
                    fails++;
                    $display("FAIL stall_stable: actual=%b/%h/%b/%b required=1/%h/%b/%b",
                             o_valid, o_data, o_keep, o_last, p_d, p_k, p_l);
                end
            end
            if (o_valid && i_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: actual=%h/%b/%b required=no_word", o_data, o_keep, o_last);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (o_data !== e.d || o_keep !== e.k || o_last !== e.l) begin
                        fails++;
                        $display("FAIL word: actual=%h/%b/%b required=%h/%b/%b",
                                 o_data, o_keep, o_last, e.d, e.k, e.l);
                    end
                end
            end
            if (use_model && i_valid && o_ready) begin
                m_lane[m_cnt] = i_data;
                m_cnt++;
                if (m_cnt == 4 || i_last) begin
                    exp_t e;
                    e.d = '0;
                    e.k = '0;
                    for (int i = 0; i < m_cnt; i++) begin
                        e.d = e.d | (32'(m_lane[i]) << (8 * i));
                        e.k[i] = 1'b1;
                    end
                    e.l = i_last;
                    exp_q.push_back(e);
                    m_cnt = 0;
                end
            end
            prev_stall = o_valid && !i_ready;
            p_d = o_data;
            p_k = o_keep;
            p_l = o_last;
        end
    end

    initial begin
        int w;
        int wsum;
        int drops;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_ready", 64'(o_ready), 64'd0);
        chk("rst_o_data",  64'(o_data),  64'd0);
        chk("rst_o_keep",  64'(o_keep),  64'd0);
        chk("rst_o_last",  64'(o_last),  64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", 64'(o_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_edge", 64'(o_ready), 64'd1);
        idle(1);

        // Full word, back-to-back, 1-cycle latency.
        push_exp(32'h44332211, 4'b1111, 1'b0);
        wsum = 0;
        send(8'h11, 1'b0, w); wsum += w;
        send(8'h22, 1'b0, w); wsum += w;
        send(8'h33, 1'b0, w); wsum += w;
        send(8'h44, 1'b0, w); wsum += w;
        @(negedge clk);
        chk("latency_valid", 64'(o_valid), 64'd1);
        chk("b2b_cycles", 64'(wsum), 64'd4);
        idle(3);

        push_exp(32'h0000BBAA, 4'b0011, 1'b1);
        send(8'hAA, 1'b0, w);
        send(8'hBB, 1'b1, w);
        idle(3);

        push_exp(32'h0000005A, 4'b0001, 1'b1);
        send(8'h5A, 1'b1, w);
        idle(3);

        // Downstream stall forces the second word into PEND.
        i_ready = 1'b0;
        push_exp(32'h04030201, 4'b1111, 1'b0);
        push_exp(32'h08070605, 4'b1111, 1'b0);
        for (int b = 1; b <= 8; b++) send(8'(b), 1'b0, w);
        @(negedge clk);
        chk("pend_ready_low", 64'(o_ready), 64'd0);
        chk("pend_valid_high", 64'(o_valid), 64'd1);
        idle(3);
        i_ready = 1'b1;
        idle(6);
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a packet discards the partial word.
        send(8'hE1, 1'b0, w);
        send(8'hE2, 1'b0, w);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_valid", 64'(o_valid), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        push_exp(32'h04030201, 4'b1111, 1'b0);
        for (int b = 1; b <= 4; b++) send(8'(b), 1'b0, w);
        idle(5);
        chk("midrst_drained", 64'(exp_q.size()), 64'd0);

        // Randomized traffic against the packing model.
        use_model = 1;
        drops = 0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            if (c < 3000 && c > 0 && !o_ready) drops++;
            i_valid = ($urandom_range(0, 3) != 0);
            i_data  = 8'($urandom);
            i_last  = ($urandom_range(0, 4) == 0);
            i_ready = (c < 3000) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        chk("throughput_ready_held", 64'(drops), 64'd0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        idle(20);
        chk("random_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
